// File: rtl/stat_page_scan_ctrl.sv
// stat_page_scan_ctrl
//   Steps the 3-bit statistics page code on a debounced button press or an
//   automatic timer, snapshots the selected 32-bit value once the selector has
//   settled, and scans that snapshot over an 8-digit active-low 7-segment display.
//   Optional feature macro: LEADING_ZERO_BLANK_EN blanks leading zero digits
//   (digit 0 always stays lit). Without it all eight digits are shown.
//   dbg_state exposes the FSM state: 1 = SETTLE_ST, 0 = SHOW.
module stat_page_scan_ctrl #(
  parameter int DEB_CYCLES  = 1000000,
  parameter int SCAN_CYCLES = 100000,
  parameter int AUTO_CYCLES = 200000000,
  parameter int SETTLE      = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_next,
  input  logic        auto_en,
  input  logic [31:0] disp_value,
  output logic [2:0]  page_sel,
  output logic        page_change,
  output logic [7:0]  an,
  output logic [7:0]  seg,
  output logic        dbg_state
);

  localparam int DEB_W  = (DEB_CYCLES  > 1) ? $clog2(DEB_CYCLES)  : 1;
  localparam int SCAN_W = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
  localparam int AUTO_W = (AUTO_CYCLES > 1) ? $clog2(AUTO_CYCLES) : 1;
  localparam int SET_W  = (SETTLE      > 1) ? $clog2(SETTLE)      : 1;

  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_CYCLES - 1);
  localparam logic [AUTO_W-1:0] AUTO_LAST = AUTO_W'(AUTO_CYCLES - 1);
  localparam logic [SET_W-1:0]  SET_LAST  = SET_W'(SETTLE - 1);

  typedef enum logic [0:0] {
    SHOW      = 1'b0,
    SETTLE_ST = 1'b1
  } state_t;

  state_t             state, state_nxt;
  logic               sync0, sync1;
  logic               deb_raw, btn_acc, btn_acc_d;
  logic [DEB_W-1:0]   deb_cnt;
  logic [AUTO_W-1:0]  auto_cnt;
  logic [SCAN_W-1:0]  scan_cnt;
  logic [2:0]         idx;
  logic [SET_W-1:0]   settle_cnt;
  logic [31:0]        snapshot;
  logic               btn_req, auto_tick, step_req, step_take, settle_done;
  logic               scan_adv, frame_wrap;
  logic [7:0]         an_nxt, seg_nxt;

  // Active-low gfedcba pattern for one hex nibble.
  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h40;
      4'h1: hex7 = 7'h79;
      4'h2: hex7 = 7'h24;
      4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;
      4'h5: hex7 = 7'h12;
      4'h6: hex7 = 7'h02;
      4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;
      4'h9: hex7 = 7'h10;
      4'hA: hex7 = 7'h08;
      4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;
      4'hD: hex7 = 7'h21;
      4'hE: hex7 = 7'h06;
      default: hex7 = 7'h0E;
    endcase
  endfunction

  // Synchronize the raw button, then accept a level only after it has held
  // steady for DEB_CYCLES; any change of the synchronized level restarts the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync0     <= 1'b0;
      sync1     <= 1'b0;
      deb_raw   <= 1'b0;
      deb_cnt   <= '0;
      btn_acc   <= 1'b0;
      btn_acc_d <= 1'b0;
    end else begin
      sync0     <= btn_next;
      sync1     <= sync0;
      btn_acc_d <= btn_acc;
      if (sync1 != deb_raw) begin
        deb_raw <= sync1;
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_LAST) begin
        btn_acc <= deb_raw;
      end else begin
        deb_cnt <= deb_cnt + DEB_W'(1);
      end
    end
  end

  // Button and timer requests merge into one request, so a coincident pair
  // still advances the page only once.
  assign btn_req   = btn_acc & ~btn_acc_d;
  assign auto_tick = auto_en && (state == SHOW) && (auto_cnt == AUTO_LAST);
  assign step_req  = btn_req | auto_tick;
  assign scan_adv  = (scan_cnt == SCAN_LAST);
  assign frame_wrap = scan_adv && (idx == 3'd7);
  assign dbg_state = (state == SETTLE_ST);

  // Next-state logic: SHOW takes a step, SETTLE_ST waits for the selector and
  // ignores any request that arrives meanwhile.
  always_comb begin
    state_nxt   = state;
    step_take   = 1'b0;
    settle_done = 1'b0;
    case (state)
      SHOW: begin
        if (step_req) begin
          step_take = 1'b1;
          state_nxt = SETTLE_ST;
        end
      end
      SETTLE_ST: begin
        if (settle_cnt == SET_LAST) begin
          settle_done = 1'b1;
          state_nxt   = SHOW;
        end
      end
      default: state_nxt = SETTLE_ST;
    endcase
  end

  // State, page code, settle/auto counters and the displayed snapshot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= SETTLE_ST;
      page_sel    <= 3'd0;
      page_change <= 1'b0;
      settle_cnt  <= '0;
      auto_cnt    <= '0;
      snapshot    <= 32'd0;
    end else begin
      state       <= state_nxt;
      page_change <= step_take;
      if (step_take) page_sel <= page_sel + 3'd1;
      if (state == SETTLE_ST && !settle_done) settle_cnt <= settle_cnt + SET_W'(1);
      else settle_cnt <= '0;
      if (!auto_en || step_take) auto_cnt <= '0;
      else if (state == SHOW) auto_cnt <= auto_cnt + AUTO_W'(1);
      // Reloading only at frame boundaries keeps every frame self-consistent.
      if (settle_done || (state == SHOW && frame_wrap)) snapshot <= disp_value;
    end
  end

  // Digit scan timer; free-runs in every state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt <= '0;
      idx      <= 3'd0;
    end else if (scan_adv) begin
      scan_cnt <= '0;
      idx      <= idx + 3'd1;
    end else begin
      scan_cnt <= scan_cnt + SCAN_W'(1);
    end
  end

  // Digit enable and segment pattern for the current index.
  always_comb begin
    an_nxt = ~(8'b1 << idx);
`ifdef LEADING_ZERO_BLANK_EN
    if (idx != 3'd0 && (snapshot >> {idx, 2'b00}) == 32'd0) an_nxt = 8'hFF;
`endif
    if (state == SETTLE_ST) an_nxt = 8'hFF;
    seg_nxt = {~(auto_en && idx == 3'd7), hex7(snapshot[{idx, 2'b00} +: 4])};
  end

  // Registered display drive, one cycle behind the index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an  <= 8'hFF;
      seg <= 8'hFF;
    end else begin
      an  <= an_nxt;
      seg <= seg_nxt;
    end
  end

endmodule

// File: tb/tb_stat_page_scan_ctrl.sv
// Bench for stat_page_scan_ctrl with small timing parameters. A behavioural
// model predicts page, pulse and display outputs from elapsed time, stability
// windows and frame boundaries; page steps also go through an expected queue.
module tb_stat_page_scan_ctrl;

  localparam int DEB_T = 4, SCAN_T = 3, AUTO_T = 50, SETTLE_T = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        btn_next = 1'b0;
  logic        auto_en = 1'b0;
  logic [31:0] disp_value = 32'd0;
  logic [2:0]  page_sel;
  logic        page_change;
  logic [7:0]  an, seg;
  logic        dbg_state;

  logic [31:0] page_vals [8];
  logic [6:0]  hex_tab [16];
  logic [2:0]  exp_q[$];
  int          errors = 0, checks = 0, pc_count = 0;

  // model state
  bit          m_s0, m_s1, m_acc, m_acc_d, m_show, m_pc;
  bit          m_lvl[$];
  int          m_settle, m_auto, m_t, m_page;
  logic [31:0] m_snap, m_disp;
  logic [7:0]  exp_an, exp_seg;

  stat_page_scan_ctrl #(
    .DEB_CYCLES(DEB_T), .SCAN_CYCLES(SCAN_T), .AUTO_CYCLES(AUTO_T), .SETTLE(SETTLE_T)
  ) dut (
    .clk(clk), .rst(rst), .btn_next(btn_next), .auto_en(auto_en),
    .disp_value(disp_value), .page_sel(page_sel), .page_change(page_change),
    .an(an), .seg(seg), .dbg_state(dbg_state)
  );

  // clock / selector stand-in (1-cycle registered lookup) / watchdog
  always #5 clk = ~clk;
  always @(posedge clk) disp_value <= page_vals[page_sel];
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] rand_val();
    int k = $urandom_range(0, 8);
    logic [63:0] m = (64'd1 << (4 * k)) - 64'd1;
    return $urandom & m[31:0];
  endfunction

  function automatic logic [7:0] an_for(input int i, input logic [31:0] v);
    logic [7:0] a = 8'hFF;
    a[i] = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    if (i > 0 && longint'(v) < (longint'(1) << (4 * i))) a = 8'hFF;
`endif
    return a;
  endfunction

  task automatic reset_model();
    m_s0 = 0; m_s1 = 0; m_acc = 0; m_acc_d = 0; m_show = 0; m_pc = 0;
    m_lvl.delete();
    for (int i = 0; i <= DEB_T; i++) m_lvl.push_back(1'b0);
    m_settle = SETTLE_T; m_auto = 0; m_t = 0; m_page = 0; m_snap = 32'd0;
    exp_an = 8'hFF; exp_seg = 8'hFF;
    exp_q.delete();
  endtask

  // One clock edge of the reference behaviour, from values seen before the edge.
  task automatic model_edge();
    int          i, nib;
    bit          show_old, btn_s, btn_req, tick, step, all_eq;
    logic [31:0] snap_n;
    show_old = m_show;
    i        = (m_t / SCAN_T) % 8;
    nib      = int'((m_snap >> (4 * i)) & 32'hF);
    exp_an   = show_old ? an_for(i, m_snap) : 8'hFF;
    exp_seg  = {(auto_en && i == 7) ? 1'b0 : 1'b1, hex_tab[nib]};
    // button: 2-cycle sync, then DEB_T+1 equal samples accept a level
    btn_s = m_s1; m_s1 = m_s0; m_s0 = btn_next;
    m_lvl.push_back(btn_s);
    if (m_lvl.size() > DEB_T + 1) void'(m_lvl.pop_front());
    btn_req = m_acc && !m_acc_d;
    m_acc_d = m_acc;
    all_eq = 1;
    foreach (m_lvl[j]) if (m_lvl[j] != btn_s) all_eq = 0;
    if (all_eq) m_acc = btn_s;
    tick = auto_en && show_old && (m_auto == AUTO_T - 1);
    step = show_old && (btn_req || tick);
    snap_n = m_snap;
    if (show_old && ((m_t + 1) % (8 * SCAN_T) == 0)) snap_n = m_disp;
    if (!show_old) begin
      m_settle--;
      if (m_settle == 0) begin
        snap_n = m_disp;
        m_show = 1;
      end
    end
    if (!auto_en || step) m_auto = 0;
    else if (show_old) m_auto++;
    m_disp = page_vals[m_page];
    if (step) begin
      m_page = (m_page + 1) % 8;
      exp_q.push_back(3'(m_page));
      m_show = 0;
      m_settle = SETTLE_T;
    end
    m_pc = step;
    m_snap = snap_n;
    m_t++;
  endtask

  // Advance one cycle, update the model, compare away from the active edge.
  task automatic cyc();
    @(posedge clk);
    if (rst) begin
      reset_model();
      m_disp = page_vals[0];
    end else begin
      model_edge();
    end
    @(negedge clk);
    check("page_sel", page_sel, m_page);
    check("page_change", page_change, m_pc);
    check("an", an, exp_an);
    check("seg", seg, exp_seg);
    check("dbg_state", dbg_state, !m_show);
    if (page_change) begin
      pc_count++;
      if (exp_q.size() == 0) check("page_seq_extra", page_change, 1'b0);
      else check("page_seq", page_sel, exp_q.pop_front());
    end
  endtask

  task automatic press(input int hold);
    btn_next = 1'b1;
    repeat (hold) cyc();
    btn_next = 1'b0;
    repeat (hold) cyc();
  endtask

  task automatic release_and_measure();
    int n = 0;
    rst = 1'b0;
    do begin
      cyc();
      n++;
    end while (an == 8'hFF && n < 20);
    check("first_digit_lat", n, SETTLE_T + 1);
  endtask

  initial begin
    int n, c0, p0, nblank;
    hex_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    page_vals[0] = 32'h1234_ABCD;
    page_vals[1] = 32'h8765_4321;
    page_vals[2] = 32'h0000_0A05;
    page_vals[3] = 32'h0000_0000;
    for (int i = 4; i < 8; i++) page_vals[i] = rand_val();
    reset_model();
    m_disp = 32'd0;

    // power-on reset
    #1 rst = 1'b1;
    repeat (4) cyc();
    check("rst_page", page_sel, 3'd0);
    check("rst_an", an, 8'hFF);
    check("rst_seg", seg, 8'hFF);
    release_and_measure();

    // steady display of page 0, no paging
    repeat (60) cyc();

    // bouncing press: 1-0-1 then held high
    c0 = pc_count; nblank = 0;
    btn_next = 1'b1; cyc(); if (an == 8'hFF) nblank++;
    btn_next = 1'b0; cyc(); if (an == 8'hFF) nblank++;
    btn_next = 1'b1;
    repeat (10) begin cyc(); if (an == 8'hFF) nblank++; end
    btn_next = 1'b0;
    repeat (14) begin cyc(); if (an == 8'hFF) nblank++; end
    check("bounce_steps", pc_count - c0, 1);
    check("bounce_page", page_sel, 3'd1);
    check("settle_blank", nblank, SETTLE_T);

    // clean presses up to page 7
    n = 0;
    while (m_page != 7 && n < 10) begin press(8); n++; end
    check("page7", page_sel, 3'd7);

    // auto step wraps 7->0; button request lands during settle and is dropped
    auto_en = 1'b1;
    n = 0;
    while (!(m_show && m_auto == AUTO_T - 3 - DEB_T) && n < 200) begin cyc(); n++; end
    check("wait_drop_bound", n < 200, 1'b1);
    btn_next = 1'b1;
    repeat (12) cyc();
    check("wrap_drop", page_sel, 3'd0);
    btn_next = 1'b0;
    repeat (12) cyc();
    check("drop_stays", page_sel, 3'd0);

    // button request coincides with the auto tick
    n = 0;
    while (!(m_show && m_auto == AUTO_T - 4 - DEB_T) && n < 200) begin cyc(); n++; end
    check("wait_dual_bound", n < 200, 1'b1);
    p0 = m_page; c0 = pc_count;
    btn_next = 1'b1;
    n = 0;
    while (pc_count == c0 && n < 40) begin cyc(); n++; end
    check("dual_step", page_sel, 3'((p0 + 1) % 8));
    c0 = pc_count;
    n = 0;
    while (pc_count == c0 && n < 200) begin cyc(); n++; end
    check("auto_period", n, SETTLE_T + AUTO_T);
    check("auto_next_page", page_sel, 3'((p0 + 2) % 8));
    btn_next = 1'b0;

    // randomized buttons, auto switch and selector contents
    for (int k = 0; k < 220; k++) begin
      if ($urandom_range(0, 9) == 0) auto_en = ~auto_en;
      if ($urandom_range(0, 3) == 0) page_vals[$urandom_range(0, 7)] = rand_val();
      btn_next = 1'($urandom_range(0, 1));
      repeat ($urandom_range(1, 12)) cyc();
    end

    // reset in the middle of a frame
    btn_next = 1'b0;
    repeat (4) cyc();
    rst = 1'b1;
    #1;
    check("mid_rst_page", page_sel, 3'd0);
    check("mid_rst_pc", page_change, 1'b0);
    check("mid_rst_an", an, 8'hFF);
    check("mid_rst_seg", seg, 8'hFF);
    repeat (5) cyc();
    release_and_measure();
    auto_en = 1'b1;
    press(8);
    repeat (80) cyc();

    check("exp_q_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
